board_reset_ctl: RTL and testbench
==================================

Name: board_reset_ctl

Overview:
Board-level reset and button conditioner that sits directly upstream of the SoC `dut` instance on the board top. It takes the raw asynchronous user button and the PLL lock indication, and produces a clean, debounced, synchronous active-high reset for the core. It also produces a debounced button level and one-cycle press/release strobes for general use.

Parameters:
- BOARD_CK, 32000000: core clock frequency in Hz; informational only, used to size defaults.
- DEBOUNCE_CK, 320000: cycles the synchronized button must stay at a new level before it is accepted (10 ms at 32 MHz). Must be ≥1.
- HOLD_CYCLES, 16: consecutive qualifying cycles required before rst_out is released. Must be ≥1.
- BTN_ACTIVE_LOW, 1: 1 means btn_raw=0 is pressed; 0 means btn_raw=1 is pressed.

Ports:
- clk, input, 1: core clock (PLL output).
- reset, input, 1: synchronous active-high power-on reset.
- btn_raw, input, 1: raw user button, asynchronous to clk.
- pll_locked, input, 1: PLL lock flag, treated as synchronous to clk.
- rst_out, output, 1: active-high reset to the core, registered.
- btn_level, output, 1: debounced button state; 1 = pressed.
- btn_press, output, 1: one-cycle strobe on debounced press.
- btn_release, output, 1: one-cycle strobe on debounced release.

Behaviour:
- All state updates on the rising edge of clk. Reset is synchronous and active-high.
- Values while/after reset:
  - rst_out=1, btn_level=0, btn_press=0, btn_release=0.
  - Synchronizer flops hold the released level (after polarity normalisation).
  - Debounce counter=0, hold counter=0, FSM=HOLD.
- Synchronizer:
  - Polarity normalised first (pressed → 1).
  - Then two flip-flops, sync1→sync2.
  - No logic may sit between sync1 and sync2.
- Debounce:
  - If sync2==btn_level: counter clears to 0.
  - Otherwise counter increments by 1.
  - When the counter equals DEBOUNCE_CK-1 and sync2!=btn_level: on that edge btn_level<=sync2 and the counter clears.
  - On the same edge, btn_press (0→1) or btn_release (1→0) is registered high for exactly one cycle.
  - Any glitch back to btn_level before the count completes restarts the count from 0.
  - Counter width is $clog2(DEBOUNCE_CK+1); it never wraps.
- Latency: a clean raw edge appears on btn_level DEBOUNCE_CK+2 cycles after the first clk edge that samples it.
- Reset FSM, two states:
  - HOLD: rst_out=1.
    - Hold counter increments while pll_locked=1 and btn_level=0; otherwise it clears.
    - When the hold counter equals HOLD_CYCLES-1 and the condition still holds: next state RUN, rst_out<=0, counter<=0.
  - RUN: rst_out=0.
    - pll_locked=0 → HOLD, with rst_out<=1 on that edge.
    - Debounced press (same edge btn_level rises) → HOLD, with rst_out<=1 on that edge, coincident with btn_press.
- rst_out deassertion:
  - rst_out falls HOLD_CYCLES cycles after both pll_locked=1 and btn_level=0 hold continuously.
  - While held in HOLD, rst_out stays high for as long as the button is held or the PLL is unlocked.
- Simultaneous events:
  - pll_locked falling on the same edge the hold count completes: stays in HOLD, counter clears.
  - Debounced press on the same cycle pll_locked drops in RUN: single transition to HOLD.
- Reset mid-operation: any pending debounce or hold count is discarded, outputs return to their reset values, and btn_level returns to 0 even if the button is physically held. It re-asserts only after a full DEBOUNCE_CK qualification.
- rst_out is glitch-free: it is driven from a single flop.

Test Plan:
All scenarios use DEBOUNCE_CK=8, HOLD_CYCLES=4, BTN_ACTIVE_LOW=1.
1. Power-up release: reset high 3 cycles, then low; pll_locked=1, btn_raw=1 → rst_out stays 1 for exactly 4 cycles after reset falls, then 0 permanently; btn_level=0; no strobes.
2. PLL lock late: pll_locked=0 for 20 cycles after reset, then 1 → rst_out=1 throughout, falls exactly 4 cycles after pll_locked rises.
3. Clean press in RUN: btn_raw 1→0 and held → btn_level and btn_press rise 10 cycles later; btn_press high 1 cycle; rst_out rises on the same edge.
4. Hold then release: keep btn_raw=0 for 50 cycles, then 1 → btn_release pulses 10 cycles after release; rst_out falls 4 cycles after btn_level falls.
5. Bounce rejection: in RUN, btn_raw low 5 cycles, high 2, low 5, then high → no btn_press, btn_level stays 0, rst_out stays 0.
6. Reset mid-debounce and PLL drop in RUN:
   - Assert reset after 5 cycles of a held press → all outputs return to reset values; btn_level rises only after a further full 10-cycle qualification.
   - Separately, drop pll_locked for 1 cycle in RUN → rst_out=1 on the next edge, then 0 four cycles after lock returns.

Source files
------------

// File: rtl/board_reset_ctl.sv
// Board reset and button conditioner: synchronises and debounces the user button,
// and holds the core in reset until the PLL is locked and the button is released.
module board_reset_ctl #(
  parameter int BOARD_CK       = 32000000,
  parameter int DEBOUNCE_CK    = 320000,
  parameter int HOLD_CYCLES    = 16,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic pll_locked,
  output logic rst_out,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int DB_W = $clog2(DEBOUNCE_CK + 1);
  localparam int HC_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CK - 1);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_CYCLES - 1);

  if (BOARD_CK < 1) begin : g_bad_board_ck
    $error("BOARD_CK must be positive");
  end
  if (DEBOUNCE_CK < 1) begin : g_bad_debounce_ck
    $error("DEBOUNCE_CK must be at least 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
    $error("HOLD_CYCLES must be at least 1");
  end

  typedef enum logic [0:0] {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  logic            btn_norm_s;
  logic            sync1_d, sync1_q;
  logic            sync2_q;
  logic [DB_W-1:0] db_cnt_d, db_cnt_q;
  logic            btn_level_d, btn_level_q;
  logic            btn_press_d, btn_press_q;
  logic            btn_release_d, btn_release_q;
  logic            db_fire_s;
  logic            hold_ok_s;
  logic [HC_W-1:0] hold_cnt_d, hold_cnt_q;
  state_e          state_d, state_q;
  logic            rst_out_d, rst_out_q;

  // Polarity is normalised before the synchroniser so every flop holds "pressed = 1".
  assign btn_norm_s = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
  assign sync1_d    = btn_norm_s;
  assign hold_ok_s  = pll_locked & ~btn_level_q;

  always_comb begin
    db_cnt_d      = db_cnt_q;
    btn_level_d   = btn_level_q;
    btn_press_d   = 1'b0;
    btn_release_d = 1'b0;
    db_fire_s     = 1'b0;
    if (sync2_q == btn_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_fire_s     = 1'b1;
      db_cnt_d      = '0;
      btn_level_d   = sync2_q;
      btn_press_d   = sync2_q;
      btn_release_d = ~sync2_q;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      db_cnt_q      <= '0;
      btn_level_q   <= 1'b0;
      btn_press_q   <= 1'b0;
      btn_release_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync1_q;
      db_cnt_q      <= db_cnt_d;
      btn_level_q   <= btn_level_d;
      btn_press_q   <= btn_press_d;
      btn_release_q <= btn_release_d;
    end
  end

  // Reset FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      rst_out_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rst_out_q  <= rst_out_d;
    end
  end

  // Reset FSM: next state. A press re-enters HOLD on the same edge btn_level rises.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_HOLD: begin
        if (hold_ok_s) begin
          if (hold_cnt_q == HC_LAST) begin
            state_d    = ST_RUN;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HC_W'(1);
          end
        end else begin
          hold_cnt_d = '0;
        end
      end
      ST_RUN: begin
        hold_cnt_d = '0;
        if (!pll_locked || (db_fire_s && sync2_q)) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
      end
    endcase
  end

  // Reset FSM: output, registered so rst_out comes from a single flop.
  always_comb begin
    if (state_d == ST_HOLD) begin
      rst_out_d = 1'b1;
    end else begin
      rst_out_d = 1'b0;
    end
  end

  assign rst_out     = rst_out_q;
  assign btn_level   = btn_level_q;
  assign btn_press   = btn_press_q;
  assign btn_release = btn_release_q;

endmodule

// File: tb/tb_board_reset_ctl.sv
// Directed bench for board_reset_ctl with DEBOUNCE_CK=8, HOLD_CYCLES=4, active-low button.
module tb_board_reset_ctl;

  logic clk = 1'b0;
  logic reset;
  logic btn_raw;
  logic pll_locked;
  logic rst_out;
  logic btn_level;
  logic btn_press;
  logic btn_release;

  int checks = 0;
  int errors = 0;

  board_reset_ctl #(
    .BOARD_CK      (32000000),
    .DEBOUNCE_CK   (8),
    .HOLD_CYCLES   (4),
    .BTN_ACTIVE_LOW(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .pll_locked (pll_locked),
    .rst_out    (rst_out),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic e_rst, input logic e_lvl,
                            input logic e_prs, input logic e_rel);
    check_eq({tag, ".rst_out"}, rst_out, e_rst);
    check_eq({tag, ".btn_level"}, btn_level, e_lvl);
    check_eq({tag, ".btn_press"}, btn_press, e_prs);
    check_eq({tag, ".btn_release"}, btn_release, e_rel);
  endtask

  logic bounce_pat [24];

  initial begin
    reset      = 1'b1;
    btn_raw    = 1'b1;
    pll_locked = 1'b1;

    // 1: power-up release, rst_out falls 4 edges after reset drops
    for (int i = 1; i <= 3; i++) begin
      step();
      expect_out($sformatf("s1_rst[%0d]", i), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      expect_out($sformatf("s1[%0d]", i), (i < 4), 1'b0, 1'b0, 1'b0);
    end

    // 2: PLL lock arrives late
    reset      = 1'b1;
    pll_locked = 1'b0;
    step();
    step();
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      expect_out($sformatf("s2_unlocked[%0d]", i), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    pll_locked = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      expect_out($sformatf("s2_lock[%0d]", i), (i < 4), 1'b0, 1'b0, 1'b0);
    end

    // 3: clean press in RUN
    btn_raw = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      expect_out($sformatf("s3[%0d]", i), (i >= 10), (i >= 10), (i == 10), 1'b0);
    end

    // 4: hold for 50 cycles total, then release
    for (int i = 1; i <= 38; i++) begin
      step();
      expect_out($sformatf("s4_held[%0d]", i), 1'b1, 1'b1, 1'b0, 1'b0);
    end
    btn_raw = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      expect_out($sformatf("s4_rel[%0d]", i), (i < 14), (i < 10), 1'b0, (i == 10));
    end

    // 5: bounce rejection (low 5, high 2, low 5, then high)
    for (int i = 0; i < 24; i++) begin
      bounce_pat[i] = ((i < 5) || (i >= 7 && i < 12)) ? 1'b0 : 1'b1;
    end
    for (int i = 0; i < 24; i++) begin
      btn_raw = bounce_pat[i];
      step();
      expect_out($sformatf("s5[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // 6a: reset in the middle of a debounce discards the partial count
    btn_raw = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      expect_out($sformatf("s6a_pre[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      step();
      expect_out($sformatf("s6a_rst[%0d]", i), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      expect_out($sformatf("s6a_post[%0d]", i), !(i >= 4 && i < 10), (i >= 10), (i == 10), 1'b0);
    end
    btn_raw = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      expect_out($sformatf("s6a_rel[%0d]", i), (i < 14), (i < 10), 1'b0, (i == 10));
    end

    // 6b: one-cycle PLL drop in RUN
    pll_locked = 1'b0;
    step();
    expect_out("s6b_drop", 1'b1, 1'b0, 1'b0, 1'b0);
    pll_locked = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      expect_out($sformatf("s6b_lock[%0d]", i), (i < 4), 1'b0, 1'b0, 1'b0);
    end

    // 7: lock lost on the edge the hold count would complete
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      expect_out($sformatf("s7_cnt[%0d]", i), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    pll_locked = 1'b0;
    step();
    expect_out("s7_collide", 1'b1, 1'b0, 1'b0, 1'b0);
    pll_locked = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      expect_out($sformatf("s7_lock[%0d]", i), (i < 4), 1'b0, 1'b0, 1'b0);
    end

    // 8: debounced press and PLL drop on the same edge in RUN
    btn_raw = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      expect_out($sformatf("s8_pre[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    pll_locked = 1'b0;
    step();
    expect_out("s8_both", 1'b1, 1'b1, 1'b1, 1'b0);
    pll_locked = 1'b1;
    btn_raw    = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      expect_out($sformatf("s8_rel[%0d]", i), (i < 14), (i < 10), 1'b0, (i == 10));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
